// File: rtl/rca_lsq_responder.sv
// rca_lsq_responder: responder end of the RCA PR-module load/store interface.
// Requests are queued in order and issued one at a time to a single-port
// data memory; load results come back on load_data/load_complete.
// Optional build macro RCA_LSQ_STATS_EN adds load/store/full-cycle counters.
module rca_lsq_responder #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,          // active-low, asynchronous
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] data,
  input  logic [2:0]      fn3,
  input  logic            load,
  input  logic            store,
  input  logic            new_request,
  output logic            lsq_full,
  output logic [XLEN-1:0] load_data,
  output logic            load_complete,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_we,
  output logic [3:0]      mem_be,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ack,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata
`ifdef RCA_LSQ_STATS_EN
  ,
  output logic [31:0]     stat_loads,
  output logic [31:0]     stat_stores,
  output logic [31:0]     stat_full_cycles
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t          r_state, w_state_nxt;
  logic [XLEN-1:0] r_q_addr [DEPTH];
  logic [XLEN-1:0] r_q_data [DEPTH];
  logic [2:0]      r_q_fn3  [DEPTH];
  logic            r_q_ld   [DEPTH];
  logic [AW-1:0]   r_wp, r_rp;
  logic [CW-1:0]   r_count, w_count_nxt;
  logic            r_full;
  logic            w_enq, w_deq, w_issue;

  logic            r_is_load;
  logic [2:0]      r_fn3;
  logic [1:0]      r_off;
  logic            r_mem_req, r_mem_we, r_lc;
  logic [3:0]      r_mem_be;
  logic [XLEN-1:0] r_mem_addr, r_mem_wdata, r_load_data;

  logic [XLEN-1:0] w_h_addr, w_h_data;
  logic [2:0]      w_h_fn3;
  logic            w_h_ld;
  logic [3:0]      w_be;
  logic [XLEN-1:0] w_wdata, w_ext;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;

  // a request with load==store is neither; it is dropped here
  assign w_enq       = new_request && !r_full && (load ^ store);
  assign w_count_nxt = r_count + CW'(w_enq) - CW'(w_deq);

  assign w_h_addr = r_q_addr[r_rp];
  assign w_h_data = r_q_data[r_rp];
  assign w_h_fn3  = r_q_fn3[r_rp];
  assign w_h_ld   = r_q_ld[r_rp];

  // queue storage; contents are don't-care until written so no reset
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_q_addr[r_wp] <= addr;
      r_q_data[r_wp] <= data;
      r_q_fn3[r_wp]  <= fn3;
      r_q_ld[r_wp]   <= load;
    end
  end

  // queue pointers, occupancy and registered full flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
    end else begin
      if (w_enq) r_wp <= r_wp + 1'b1;
      if (w_deq) r_rp <= r_rp + 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(DEPTH));
    end
  end

  // store lane steering for the head entry; loads read the whole word
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = w_h_data;
    if (!w_h_ld) begin
      case (w_h_fn3)
        3'b000: begin
          w_be    = 4'b0001 << w_h_addr[1:0];
          w_wdata = {(XLEN/8){w_h_data[7:0]}};
        end
        3'b001: begin
          w_be    = w_h_addr[1] ? 4'b1100 : 4'b0011;
          w_wdata = {(XLEN/16){w_h_data[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // FSM next state and queue dequeue/issue strobes
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_deq       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_issue     = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (mem_ack) begin
          if (r_is_load) begin
            w_state_nxt = S_WAIT;
          end else begin
            w_deq       = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          w_deq       = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // issue registers: latched from the head when leaving IDLE, stable through ISSUE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= 4'b0000;
      r_mem_wdata <= '0;
      r_is_load   <= 1'b0;
      r_fn3       <= 3'b000;
      r_off       <= 2'b00;
    end else begin
      r_mem_req <= (w_state_nxt == S_ISSUE);
      if (w_issue) begin
        r_mem_addr  <= {w_h_addr[XLEN-1:2], 2'b00};
        r_mem_we    <= !w_h_ld;
        r_mem_be    <= w_be;
        r_mem_wdata <= w_wdata;
        r_is_load   <= w_h_ld;
        r_fn3       <= w_h_fn3;
        r_off       <= w_h_addr[1:0];
      end
    end
  end

  // load lane select and width/sign extension
  always_comb begin
    w_byte = mem_rdata[{r_off, 3'b000} +: 8];
    w_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_fn3)
      3'b000:  w_ext = {{(XLEN-8){w_byte[7]}}, w_byte};
      3'b001:  w_ext = {{(XLEN-16){w_half[15]}}, w_half};
      3'b100:  w_ext = {{(XLEN-8){1'b0}}, w_byte};
      3'b101:  w_ext = {{(XLEN-16){1'b0}}, w_half};
      default: w_ext = mem_rdata;
    endcase
  end

  // load result capture; load_data holds between completions
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_load_data <= '0;
      r_lc        <= 1'b0;
    end else begin
      r_lc <= 1'b0;
      if (r_state == S_WAIT && mem_rvalid) begin
        r_load_data <= w_ext;
        r_lc        <= 1'b1;
      end
    end
  end

  assign lsq_full      = r_full;
  assign load_data     = r_load_data;
  assign load_complete = r_lc;
  assign mem_req       = r_mem_req;
  assign mem_addr      = r_mem_addr;
  assign mem_we        = r_mem_we;
  assign mem_be        = r_mem_be;
  assign mem_wdata     = r_mem_wdata;

`ifdef RCA_LSQ_STATS_EN
  logic [31:0] r_st_ld, r_st_st, r_st_full;

  // free-running wrapping activity counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_st_ld   <= '0;
      r_st_st   <= '0;
      r_st_full <= '0;
    end else begin
      if (r_lc) r_st_ld <= r_st_ld + 32'd1;
      if (r_state == S_ISSUE && mem_ack && !r_is_load) r_st_st <= r_st_st + 32'd1;
      if (r_full) r_st_full <= r_st_full + 32'd1;
    end
  end

  assign stat_loads       = r_st_ld;
  assign stat_stores      = r_st_st;
  assign stat_full_cycles = r_st_full;
`endif

endmodule
